apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//   APB requester: converts single commands from a valid/ready command port into
//   APB SETUP/ACCESS transfers toward an APB completer.
//   Returns read data, or a timeout flag, on a one-cycle response strobe.
//   Sits between a local control engine and the APB slaves on the same bus.
// PARAMETERS
//   ADDR_W   32  width of cmd_addr / paddr
//   DATA_W   32  width of cmd_wdata / pwdata / prdata / rsp_rdata
//   TIMEOUT  16  max consecutive ACCESS cycles with pready=0 before abort; 0 = never abort
// PORTS
//   clk          in   1       clock; all logic on posedge
//   rst          in   1       asynchronous, active-low reset (0 = reset)
//   cmd_valid    in   1       command request
//   cmd_ready    out  1       block idle, can accept a command (state==IDLE)
//   cmd_write    in   1       1 = write, 0 = read
//   cmd_addr     in   ADDR_W  transfer address
//   cmd_wdata    in   DATA_W  write data (ignored for reads)
//   rsp_valid    out  1       one-cycle response strobe
//   rsp_rdata    out  DATA_W  read data; 0 for writes and timeouts
//   rsp_timeout  out  1       transfer aborted by timeout; qualified by rsp_valid
//   paddr        out  ADDR_W  APB address
//   psel         out  1       APB select
//   penable      out  1       APB enable
//   pwrite       out  1       APB direction
//   pwdata       out  DATA_W  APB write data
//   pready       in   1       APB ready from completer
//   prdata       in   DATA_W  APB read data from completer
// BEHAVIOUR
//   Reset (rst=0, async)
//   - psel, penable, pwrite, rsp_valid, rsp_timeout = 0.
//   - paddr, pwdata, rsp_rdata = 0; wait counter = 0; state = IDLE; cmd_ready = 1.
//   - Commands are ignored while rst=0.
//   FSM: IDLE -> SETUP -> ACCESS -> IDLE
//   - IDLE: cmd_ready=1. On cmd_valid at a clk edge:
//     - register paddr<=cmd_addr, pwrite<=cmd_write, pwdata<=cmd_wdata;
//     - psel<=1, penable<=0; go to SETUP.
//   - SETUP: lasts exactly one cycle. penable<=1; go to ACCESS. pready is ignored here.
//   - ACCESS: psel=penable=1 every cycle. pready is sampled each edge.
//     - pready=1: psel<=0, penable<=0, rsp_valid<=1, rsp_timeout<=0;
//       rsp_rdata<=prdata if read, else 0; counter<=0; go to IDLE.
//     - pready=0: counter++. If TIMEOUT>0 and counter reaches TIMEOUT:
//       psel<=0, penable<=0, rsp_valid<=1, rsp_timeout<=1, rsp_rdata<=0; go to IDLE.
//   Bus outputs
//   - paddr, pwrite and pwdata are stable from SETUP through the last ACCESS cycle.
//   - They hold their last values while IDLE and change only on command accept.
//   - penable=1 never occurs with psel=0.
//   - psel and penable are both 0 in IDLE.
//   Responses and throughput
//   - rsp_valid is high for exactly one cycle, coinciding with the first IDLE cycle.
//   - rsp_rdata and rsp_timeout hold until the next response.
//   - No response buffering: a consumer that misses the strobe loses it.
//   - Latency for a zero-wait completer: accept at edge 0, SETUP cycle 1,
//     ACCESS cycle 2, rsp_valid cycle 3 (next accept possible at edge 3).
//     Each pready=0 cycle adds 1.
//   - Back-to-back commands: at most 1 transfer per 3 cycles; transfers never overlap.
//   - cmd_valid while cmd_ready=0 has no effect; the command port fields are don't-care then.
//   Counter
//   - Wide enough for TIMEOUT; cleared on entry to IDLE; never wraps.
//   Reset mid-transfer
//   - psel and penable drop immediately (asynchronously).
//   - No response is produced for the aborted transfer.
//   - After release: IDLE, cmd_ready=1.
// TESTING
//   1. Write addr 0x10 data 0xDEADBEEF, pready=1
//      -> psel=1 at cycle 1, penable=1 at cycle 2, pwrite=1, paddr=0x10, pwdata=0xDEADBEEF;
//         rsp_valid at cycle 3, rsp_timeout=0.
//   2. Read addr 0x10; model returns 0xDEADBEEF after 2 pready=0 cycles
//      -> penable high 3 cycles, addr stable; rsp_rdata=0xDEADBEEF one cycle after pready=1.
//   3. TIMEOUT=4, pready held 0 on a read
//      -> abort after 4 ACCESS cycles; rsp_valid=1, rsp_timeout=1, rsp_rdata=0; psel=0.
//   4. cmd_valid held high for 3 writes (0x0, 0x4, 0x8), pready=1
//      -> accepts exactly 3 cycles apart, 3 rsp_valid pulses; penable never 1 with psel=0.
//   5. rst=0 asserted mid-ACCESS
//      -> psel, penable, rsp_valid = 0 immediately; after release cmd_ready=1 and no stale rsp_valid.
//   6. cmd_valid with new fields during ACCESS
//      -> ignored; paddr/pwdata unchanged; only the original transfer completes.

Source files
------------

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB requester turning valid/ready commands into SETUP/ACCESS transfers
// Single outstanding transfer; response is a one-cycle strobe with optional wait-state timeout abort.
module apb_master_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [ADDR_W-1:0]   paddr_d;
   logic [DATA_W-1:0]   pwdata_d, rsp_rdata_d;
   logic                psel_d, penable_d, pwrite_d;
   logic                rsp_valid_d, rsp_timeout_d;

   assign cmd_ready = (state == IDLE);

   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      paddr_d       = paddr;
      pwrite_d      = pwrite;
      pwdata_d      = pwdata;
      psel_d        = psel;
      penable_d     = penable;
      rsp_valid_d   = 1'b0;
      rsp_timeout_d = rsp_timeout;
      rsp_rdata_d   = rsp_rdata;

      case (state)
         IDLE: begin
            cnt_d = '0;
            if (cmd_valid) begin
               paddr_d   = cmd_addr;
               pwrite_d  = cmd_write;
               pwdata_d  = cmd_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = pwrite ? '0 : prdata;
               cnt_d         = '0;
               state_d       = IDLE;
            end else if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
               // This cycle is the TIMEOUT-th consecutive wait state.
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
               cnt_d         = '0;
               state_d       = IDLE;
            end else if (cnt != CNT_MAX) begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            cnt_d     = '0;
            state_d   = IDLE;
         end
      endcase
   end

   // Async reset drops psel/penable immediately, even mid-transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         paddr       <= '0;
         pwrite      <= 1'b0;
         pwdata      <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         paddr       <= paddr_d;
         pwrite      <= pwrite_d;
         pwdata      <= pwdata_d;
         psel        <= psel_d;
         penable     <= penable_d;
         rsp_valid   <= rsp_valid_d;
         rsp_timeout <= rsp_timeout_d;
         rsp_rdata   <= rsp_rdata_d;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge
// Directed steps plus randomized transfers against a memory-backed completer model.
module tb_apb_master_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] paddr;
   logic          psel, penable, pwrite;
   logic [DW-1:0] pwdata;
   logic          pready;
   logic [DW-1:0] prdata;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [logic [31:0]];

   always #5 clk = ~clk;

   apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pready(pready), .prdata(prdata)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Completer content: written locations hold their data, others a fixed pattern.
   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input int waits, input bit noise);
      bit          tmo;
      int          n;
      logic [31:0] exp_rd;
      tmo    = (TO > 0) && (waits >= TO);
      n      = tmo ? TO : waits + 1;
      exp_rd = (tmo || wr) ? 32'h0 : model_read(a);

      chk1("idle_ready", cmd_ready, 1'b1);
      chk1("idle_psel", psel, 1'b0);
      chk1("idle_penable", penable, 1'b0);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; pready = 1'b0;

      @(negedge clk);
      cmd_valid = noise;
      if (noise) begin
         cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
      end
      chk1("setup_psel", psel, 1'b1);
      chk1("setup_penable", penable, 1'b0);
      chk1("setup_ready", cmd_ready, 1'b0);
      chk32("setup_paddr", paddr, a);
      chk32("setup_pwdata", pwdata, d);
      chk1("setup_pwrite", pwrite, wr);
      pready = 1'($urandom_range(0, 1));
      prdata = $urandom;

      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk1("access_psel", psel, 1'b1);
         chk1("access_penable", penable, 1'b1);
         chk1("access_rsp_valid", rsp_valid, 1'b0);
         chk32("access_paddr", paddr, a);
         chk32("access_pwdata", pwdata, d);
         chk1("access_pwrite", pwrite, wr);
         pready = !tmo && (k == waits);
         prdata = (pready && !wr) ? model_read(a) : $urandom;
         if (noise) begin
            cmd_addr = $urandom; cmd_wdata = $urandom;
         end
      end

      if (!tmo && wr) mem[a] = d;
      @(negedge clk);
      cmd_valid = 1'b0; pready = 1'b0;
      chk1("rsp_valid", rsp_valid, 1'b1);
      chk1("rsp_timeout", rsp_timeout, tmo);
      chk32("rsp_rdata", rsp_rdata, exp_rd);
      chk1("rsp_psel", psel, 1'b0);
      chk1("rsp_penable", penable, 1'b0);
      chk1("rsp_ready", cmd_ready, 1'b1);
      chk32("rsp_paddr_hold", paddr, a);

      @(negedge clk);
      chk1("rsp_strobe_end", rsp_valid, 1'b0);
      chk32("rsp_rdata_hold", rsp_rdata, exp_rd);
      chk1("rsp_timeout_hold", rsp_timeout, tmo);
      chk1("post_ready", cmd_ready, 1'b1);
   endtask

   initial begin
      int          acc_cyc [3];
      int          accepts, rsp_cnt;
      logic [31:0] a;

      rst = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44;
      cmd_wdata = 32'h1234; pready = 1'b1; prdata = 32'h0;
      repeat (3) @(negedge clk);
      chk1("rst_psel", psel, 1'b0);
      chk1("rst_penable", penable, 1'b0);
      chk1("rst_pwrite", pwrite, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
      chk32("rst_paddr", paddr, 32'h0);
      chk32("rst_pwdata", pwdata, 32'h0);
      chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk1("rst_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b0; pready = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      // Directed write/read/timeout, then both sides of the timeout boundary.
      xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
      xfer(1'b0, 32'h10, 32'h0, 2, 1'b0);
      xfer(1'b0, 32'h10, 32'h0, 20, 1'b0);
      xfer(1'b1, 32'h20, 32'hCAFE_F00D, 3, 1'b0);
      xfer(1'b1, 32'h24, 32'h0BAD_0BAD, 4, 1'b0);
      xfer(1'b0, 32'h20, 32'h0, 3, 1'b1);
      xfer(1'b0, 32'h24, 32'h0, 0, 1'b1);

      // cmd_valid held high across three writes with a zero-wait completer.
      accepts = 0; rsp_cnt = 0; pready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (penable) chk1("b2b_pen_implies_psel", psel, 1'b1);
         if (rsp_valid) rsp_cnt++;
         if (psel && !penable && accepts > 0)
            chk32("b2b_setup_paddr", paddr, 32'(4 * (accepts - 1)));
         if (cmd_ready && accepts < 3) begin
            acc_cyc[accepts] = c;
            cmd_valid = 1'b1; cmd_write = 1'b1;
            cmd_addr  = 32'(4 * accepts); cmd_wdata = 32'h5000 + 32'(accepts);
            mem[cmd_addr] = cmd_wdata;
            accepts++;
         end else if (cmd_ready) begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0; pready = 1'b0;
      chk32("b2b_accepts", 32'(accepts), 32'd3);
      chk32("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      chk32("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
      chk32("b2b_rsp_count", 32'(rsp_cnt), 32'd3);
      @(negedge clk);
      xfer(1'b0, 32'h8, 32'h0, 1, 1'b0);

      // Reset asserted mid-ACCESS on a write that must leave no trace.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h7777_7777;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk1("pre_rst_penable", penable, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk1("arst_psel", psel, 1'b0);
      chk1("arst_penable", penable, 1'b0);
      chk1("arst_rsp_valid", rsp_valid, 1'b0);
      chk1("arst_ready", cmd_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
         chk1("post_rst_ready", cmd_ready, 1'b1);
         chk1("post_rst_psel", psel, 1'b0);
      end
      xfer(1'b0, 32'h30, 32'h0, 0, 1'b0);

      // Randomized traffic over a small address window so reads hit earlier writes.
      for (int i = 0; i < 30; i++) begin
         a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
         xfer(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
